// File: rtl/switch_pkg.sv
// Shared switch definitions: default port/metadata geometry, port index type
// and the egress metadata sequencer state encoding.
package switch_pkg;

    localparam int PORT_NUM   = 4;
    localparam int META_WIDTH = 32;
    localparam int PORT_W     = $clog2(PORT_NUM);

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_grant,
// wrapping modulo N (N must be a power of two).
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant_oh,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    logic [W-1:0] cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        // Offset N wraps back onto last_grant itself, so it is searched last.
        for (int off = 1; off <= N; off++) begin
            cand = last_grant + W'(off);
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
        if (any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/egress_meta_arbiter.sv
// Shares one host read port among the per-port egress metadata queues:
// round-robin grant, one-cycle pop ack, then a settle hold-off before the next grant.
module egress_meta_arbiter #(
    parameter int PORT_NUM      = switch_pkg::PORT_NUM,
    parameter int META_WIDTH    = switch_pkg::META_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PORT_NUM-1:0]              meta_avail,
    input  logic [PORT_NUM*META_WIDTH-1:0]   meta_in,
    output logic [PORT_NUM-1:0]              meta_ack,
    input  logic                             host_rd,
    output logic                             host_waitrequest,
    output logic                             host_rd_valid,
    output logic [META_WIDTH-1:0]            host_rd_data,
    output logic [$clog2(PORT_NUM)-1:0]      host_rd_port,
    output logic                             host_rd_empty,
    output logic [PORT_NUM*16-1:0]           pop_count
);

    import switch_pkg::*;

    localparam int PW = $clog2(PORT_NUM);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_t                  state_q, state_d;
    logic [PW-1:0]           last_grant_q, last_grant_d;
    logic [CW-1:0]           settle_cnt_q, settle_cnt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [META_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [PW-1:0]           rd_port_q, rd_port_d;
    logic                    rd_empty_q, rd_empty_d;
    logic [PORT_NUM-1:0]     ack_q, ack_d;
    logic [15:0]             pop_cnt_q [PORT_NUM];
    logic [15:0]             pop_cnt_d [PORT_NUM];

    logic [META_WIDTH-1:0]   meta_words [PORT_NUM];
    logic [PORT_NUM-1:0]     grant_oh;
    logic [PW-1:0]           grant_idx;
    logic                    grant_any;

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
            assign meta_words[gi]             = meta_in[gi*META_WIDTH +: META_WIDTH];
            assign pop_count[gi*16 +: 16]     = pop_cnt_q[gi];
        end
    endgenerate

    rr_arbiter #(
        .N (PORT_NUM),
        .W (PW)
    ) u_rr_arbiter (
        .req        (meta_avail),
        .last_grant (last_grant_q),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        settle_cnt_d = settle_cnt_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rd_port_d    = rd_port_q;
        rd_empty_d   = rd_empty_q;
        ack_d        = '0;
        pop_cnt_d    = pop_cnt_q;
        case (state_q)
            IDLE: begin
                if (host_rd) begin
                    rd_valid_d = 1'b1;
                    if (grant_any) begin
                        rd_data_d            = meta_words[grant_idx];
                        rd_port_d            = grant_idx;
                        rd_empty_d           = 1'b0;
                        ack_d                = grant_oh;
                        last_grant_d         = grant_idx;
                        pop_cnt_d[grant_idx] = pop_cnt_q[grant_idx] + 16'd1;
                        state_d              = ACK;
                    end else begin
                        // Empty answer: no pop, so the next read can be taken at once.
                        rd_data_d  = '0;
                        rd_port_d  = '0;
                        rd_empty_d = 1'b1;
                    end
                end
            end
            ACK: begin
                settle_cnt_d = CW'(SETTLE_CYCLES);
                state_d      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q <= CW'(1)) begin
                    settle_cnt_d = '0;
                    state_d      = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PW'(PORT_NUM - 1);
            settle_cnt_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_port_q    <= '0;
            rd_empty_q   <= 1'b0;
            ack_q        <= '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                pop_cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            settle_cnt_q <= settle_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_port_q    <= rd_port_d;
            rd_empty_q   <= rd_empty_d;
            ack_q        <= ack_d;
            pop_cnt_q    <= pop_cnt_d;
        end
    end

    assign meta_ack         = ack_q;
    assign host_waitrequest = (state_q != IDLE);
    assign host_rd_valid    = rd_valid_q;
    assign host_rd_data     = rd_data_q;
    assign host_rd_port     = rd_port_q;
    assign host_rd_empty    = rd_empty_q;

endmodule

// File: tb/tb_egress_meta_arbiter.sv
// Directed bench for egress_meta_arbiter with hand-computed expectations.
module tb_egress_meta_arbiter;

    localparam int PN = 4;
    localparam int MW = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [PN-1:0]      meta_avail = '0;
    logic [PN*MW-1:0]   meta_in = '0;
    logic [PN-1:0]      meta_ack;
    logic               host_rd = 1'b0;
    logic               host_waitrequest;
    logic               host_rd_valid;
    logic [MW-1:0]      host_rd_data;
    logic [1:0]         host_rd_port;
    logic               host_rd_empty;
    logic [PN*16-1:0]   pop_count;

    int err_cnt = 0;
    int chk_cnt = 0;

    egress_meta_arbiter #(
        .PORT_NUM      (PN),
        .META_WIDTH    (MW),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .meta_avail       (meta_avail),
        .meta_in          (meta_in),
        .meta_ack         (meta_ack),
        .host_rd          (host_rd),
        .host_waitrequest (host_waitrequest),
        .host_rd_valid    (host_rd_valid),
        .host_rd_data     (host_rd_data),
        .host_rd_port     (host_rd_port),
        .host_rd_empty    (host_rd_empty),
        .pop_count        (pop_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int p, input logic [MW-1:0] w);
        meta_in[p*MW +: MW] = w;
    endtask

    function automatic logic [15:0] pop_of(input int p);
        return pop_count[p*16 +: 16];
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (host_waitrequest && n < 10) begin
            tick();
            n++;
        end
        check_val({tag, " idle"}, {63'd0, host_waitrequest}, 64'd0);
    endtask

    task automatic read_once(input string tag, input int exp_port, input logic [MW-1:0] exp_data);
        logic [PN-1:0] exp_ack;
        wait_idle(tag);
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        exp_ack = '0;
        exp_ack[exp_port] = 1'b1;
        check_val({tag, " valid"}, {63'd0, host_rd_valid}, 64'd1);
        check_val({tag, " port"},  {62'd0, host_rd_port}, 64'(exp_port));
        check_val({tag, " data"},  {32'd0, host_rd_data}, {32'd0, exp_data});
        check_val({tag, " ack"},   {60'd0, meta_ack}, {60'd0, exp_ack});
        check_val({tag, " empty"}, {63'd0, host_rd_empty}, 64'd0);
    endtask

    initial begin
        int k;
        int last_cyc;
        int wr_hi;
        int acks;
        int valids;
        int exp_rr [5];
        exp_rr = '{0, 1, 2, 3, 0};

        // Reset state
        tick();
        tick();
        check_val("rst valid", {63'd0, host_rd_valid}, 64'd0);
        check_val("rst waitreq", {63'd0, host_waitrequest}, 64'd0);
        check_val("rst ack", {60'd0, meta_ack}, 64'd0);
        check_val("rst data", {32'd0, host_rd_data}, 64'd0);
        check_val("rst pop", pop_count, 64'd0);
        reset = 1'b0;
        tick();

        // Single packet from port 0; inputs changed during ACK must not matter
        meta_avail = 4'b0001;
        set_word(0, 32'h12C00040);
        read_once("single", 0, 32'h12C00040);
        check_val("single waitreq", {63'd0, host_waitrequest}, 64'd1);
        check_val("single pop0", {48'd0, pop_of(0)}, 64'd1);
        set_word(0, 32'hDEADBEEF);
        tick();
        check_val("single ack drop", {60'd0, meta_ack}, 64'd0);
        check_val("single valid drop", {63'd0, host_rd_valid}, 64'd0);
        check_val("single data hold", {32'd0, host_rd_data}, 64'h12C00040);

        // Reset during ACK (grant would go to port 1 since last_grant is 0)
        for (int p = 0; p < PN; p++) set_word(p, 32'hA0000000 + 32'(p));
        meta_avail = 4'b1111;
        wait_idle("rstack");
        host_rd = 1'b1;
        tick();
        check_val("rstack ack", {60'd0, meta_ack}, 64'b0010);
        #2;
        reset = 1'b1;
        #1;
        check_val("rstack ack0", {60'd0, meta_ack}, 64'd0);
        check_val("rstack valid0", {63'd0, host_rd_valid}, 64'd0);
        check_val("rstack waitreq0", {63'd0, host_waitrequest}, 64'd0);
        check_val("rstack pop0", pop_count, 64'd0);
        tick();
        reset = 1'b0;

        // Round robin with host_rd held: 0,1,2,3,0 four cycles apart
        k = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 30 && k < 5; cyc++) begin
            tick();
            if (host_rd_valid) begin
                check_val($sformatf("rr%0d port", k), {62'd0, host_rd_port}, 64'(exp_rr[k]));
                check_val($sformatf("rr%0d data", k), {32'd0, host_rd_data},
                          64'(32'hA0000000 + 32'(exp_rr[k])));
                if (k > 0) check_val($sformatf("rr%0d gap", k), 64'(cyc - last_cyc), 64'd4);
                last_cyc = cyc;
                k++;
            end
        end
        host_rd = 1'b0;
        check_val("rr count", 64'(k), 64'd5);

        // Skip empty ports: move last_grant to 1, then 1010 -> 3,1,3
        meta_avail = 4'b0010;
        read_once("lg1", 1, 32'hA0000001);
        meta_avail = 4'b1010;
        read_once("skip a", 3, 32'hA0000003);
        read_once("skip b", 1, 32'hA0000001);
        read_once("skip c", 3, 32'hA0000003);

        // All empty, read held three cycles
        wait_idle("empty");
        meta_avail = 4'b0000;
        host_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("empty%0d valid", i), {63'd0, host_rd_valid}, 64'd1);
            check_val($sformatf("empty%0d flag", i), {63'd0, host_rd_empty}, 64'd1);
            check_val($sformatf("empty%0d data", i), {32'd0, host_rd_data}, 64'd0);
            check_val($sformatf("empty%0d ack", i), {60'd0, meta_ack}, 64'd0);
            check_val($sformatf("empty%0d waitreq", i), {63'd0, host_waitrequest}, 64'd0);
        end
        host_rd = 1'b0;
        tick();
        check_val("empty end valid", {63'd0, host_rd_valid}, 64'd0);
        check_val("empty flag hold", {63'd0, host_rd_empty}, 64'd1);

        // Busy hold-off: port 2 always available, host_rd held for 16 cycles
        meta_avail = 4'b0100;
        host_rd = 1'b1;
        wr_hi = 0;
        acks = 0;
        valids = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (host_waitrequest) wr_hi++;
            if (host_rd_valid) valids++;
            if (meta_ack != 4'b0000) begin
                acks++;
                check_val($sformatf("busy ack%0d", acks), {60'd0, meta_ack}, 64'b0100);
            end
        end
        host_rd = 1'b0;
        check_val("busy waitreq cycles", 64'(wr_hi), 64'd12);
        check_val("busy acks", 64'(acks), 64'd4);
        check_val("busy valids", 64'(valids), 64'd4);

        // Pop counters since the mid-ACK reset: p0=2 p1=3 p2=5 p3=3
        wait_idle("final");
        check_val("pop0", {48'd0, pop_of(0)}, 64'd2);
        check_val("pop1", {48'd0, pop_of(1)}, 64'd3);
        check_val("pop2", {48'd0, pop_of(2)}, 64'd5);
        check_val("pop3", {48'd0, pop_of(3)}, 64'd3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/egress_meta_arbiter.md
# egress_meta_arbiter

Sequencer that shares one host read port among the per-egress-port packet metadata queues (one `packet_val` instance per port). On each host read it picks a non-empty queue round-robin, returns that queue's head metadata word tagged with the port number, and pops the queue with a one-cycle ack pulse. It then holds off new grants until the popped queue's head and status have settled. It sits between the egress metadata queues and the Avalon-style host interface.

## Interface
- `PORT_NUM`, 4, number of egress queues (power of two, ≥2)
- `META_WIDTH`, 32, metadata word width
- `SETTLE_CYCLES`, 2, grant hold-off after a pop (≥1)

- `clk` input 1: single clock
- `reset` input 1: asynchronous, active-high reset
- `meta_avail` input PORT_NUM: per-queue non-empty flag
- `meta_in` input PORT_NUM×META_WIDTH: per-queue head word (queue `egress_out`)
- `meta_ack` output PORT_NUM: one-hot pop pulse to queue `egress_in_ack`
- `host_rd` input 1: read request, held by host while `host_waitrequest` is high
- `host_waitrequest` output 1: arbiter busy, read not accepted
- `host_rd_valid` output 1: one-cycle response strobe
- `host_rd_data` output META_WIDTH: returned metadata word
- `host_rd_port` output log2(PORT_NUM): source port of the response
- `host_rd_empty` output 1: response carries no packet (all queues empty)
- `pop_count` output PORT_NUM×16: per-port count of delivered words, wraps

## Operation
- States: IDLE, ACK, SETTLE.
- IDLE, `host_rd`=1, `meta_avail`≠0:
  - grant = first set bit of `meta_avail` searching upward (modulo PORT_NUM) from `last_grant+1`.
  - Register `host_rd_data`←`meta_in[grant]`, `host_rd_port`←grant, `host_rd_empty`←0, `host_rd_valid`←1, `meta_ack`←onehot(grant).
  - `last_grant`←grant; `pop_count[grant]`+1; go to ACK.
- IDLE, `host_rd`=1, `meta_avail`=0:
  - Register `host_rd_valid`←1, `host_rd_empty`←1, `host_rd_data`←0, `host_rd_port`←0.
  - No ack; `last_grant` unchanged; stay IDLE.
- ACK: one cycle.
  - `meta_ack` and `host_rd_valid` are high during this cycle only.
  - Load settle counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE: decrement each cycle; at 1 go to IDLE.
- `host_waitrequest` = (state≠IDLE). A read is accepted only in IDLE.
- `meta_avail` and `meta_in` are sampled only at acceptance; changes at other times are ignored.
- `pop_count` is 16-bit and wraps 0xFFFF→0x0000.
- The round-robin pointer guarantees that a port waits at most PORT_NUM−1 grants to other ports.

## Timing
- Reset values, asynchronous: state IDLE, `last_grant`=PORT_NUM−1 (so port 0 has first priority), all outputs 0, `pop_count`=0.
- Read accepted at edge E0. `host_rd_valid`, `host_rd_data` and `meta_ack` are valid in the cycle after E0: latency 1.
- Next accept occurs no earlier than SETTLE_CYCLES+2 edges after E0. Default: every 4 cycles.
- Empty response: `host_rd_valid` is high for the cycle after E0. Back-to-back empty reads may be accepted every cycle.
- `host_rd_data`, `host_rd_port` and `host_rd_empty` hold their value until the next response.
- Reset asserted mid-ACK: `meta_ack` drops immediately; the in-flight pop may be lost, which is acceptable because the queues reset together with the arbiter.
- `host_rd` is ignored while `host_waitrequest`=1; no request is queued internally.

## Structure
- Shared package `switch_pkg`: PORT_NUM, META_WIDTH, the port index type, and the state enum (IDLE/ACK/SETTLE).
- Sub-module `rr_arbiter`: combinational, PORT_NUM-wide request vector plus `last_grant` → one-hot grant, grant index and `any` flag. Reusable by the ingress crossbar scheduler.
- Top level holds the FSM, settle counter, response registers and pop counters.

## Test plan
- Single packet: `meta_avail`=0001, `meta_in[0]`=0x12C00040, read → one cycle later `host_rd_valid`=1, data 0x12C00040, port 0, `meta_ack`=0001 for exactly 1 cycle, `pop_count[0]`=1.
- Round-robin: `meta_avail`=1111 held, 5 reads → ports 0,1,2,3,0 in that order; successive `host_rd_valid` pulses are 4 cycles apart.
- Skip empty ports: `meta_avail`=1010, `last_grant`=1 → grant 3, then 1, then 3.
- All empty: `meta_avail`=0, read held for 3 cycles → 3 responses with `host_rd_empty`=1 and data 0, no `meta_ack`, `host_waitrequest` stays 0.
- Busy hold-off: `host_rd` held continuously with port 2 always available → `host_waitrequest` high for 3 of every 4 cycles; exactly one ack per response.
- Reset during ACK → `meta_ack`, `host_rd_valid` and `host_waitrequest` go 0 immediately; after release the first grant goes to port 0.
